// File: rtl/cpu24_ctrl_pkg.sv
// Shared encodings for the 24-bit CPU multi-cycle controller.
// Opcodes, FSM state codes and datapath mux select values.
// Pure definitions: no timing, no backpressure.
package cpu24_ctrl_pkg;

    // Instruction register opcode field [23:20]
    localparam logic [3:0] OP_R    = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0001;

    // FSM state encoding
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXEC_R    = 4'd3;
    localparam logic [3:0] S_MUL_START = 4'd4;
    localparam logic [3:0] S_MUL_WAIT  = 4'd5;
    localparam logic [3:0] S_WB_R      = 4'd6;
    localparam logic [3:0] S_ADDR      = 4'd7;
    localparam logic [3:0] S_MEM_RD    = 4'd8;
    localparam logic [3:0] S_WB_MEM    = 4'd9;
    localparam logic [3:0] S_MEM_WR    = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [3:0] S_BRANCH    = 4'd12;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_MUL   = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_R) || (op == OP_MUL) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags when the timeout limit is reached.
// Latency: expired_o is combinational from the registered count.
// No backpressure; counter saturates at MEM_TIMEOUT until cleared.
module mem_wait_timer #(
    parameter int TW          = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign expired_o = (count_q == TW'(MEM_TIMEOUT));

    // Clear wins over counting; hold once the limit is hit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && !expired_o) begin
            count_d = count_q + TW'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM sequencing fetch/decode/execute/memory/write-back.
// Latency: 3-5 cycles per instruction plus memory and multiplier wait cycles.
// Stalls on MemReady / MulDone; memory waits abort with BusError after MEM_TIMEOUT.
module multicycle_controller
    import cpu24_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       mul_done_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       mul_start_o,
    output logic       illegal_o,
    output logic       bus_error_o
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       is_wait;
    logic       expired;
    logic       stay;
    logic       timeout;

    // FETCH, MEM_RD and MEM_WR are the only states gated by MemReady
    assign is_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // MemReady on the expiry cycle still completes the access
    assign timeout = is_wait && !mem_ready_i && expired;
    assign stay    = is_wait && !mem_ready_i && !expired;

    // Counter runs only while stalled, so any entry to a wait state starts from zero
    mem_wait_timer #(
        .TW          (TW),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (!stay),
        .count_en_i (stay),
        .expired_o  (expired)
    );

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (mem_ready_i) state_d = S_DECODE;
                         else if (timeout) state_d = S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_R:                    state_d = S_EXEC_R;
                    OP_MUL:                  state_d = S_MUL_START;
                    OP_LW, OP_SW, OP_ADDI:   state_d = S_ADDR;
                    OP_BEQ:                  state_d = S_BRANCH;
                    default:                 state_d = S_FETCH;
                endcase
            end
            S_EXEC_R:    state_d = S_WB_R;
            S_MUL_START: state_d = S_MUL_WAIT;
            S_MUL_WAIT:  if (mul_done_i) state_d = S_WB_R;
            S_WB_R:      state_d = S_FETCH;
            S_ADDR: begin
                case (opcode_i)
                    OP_LW:   state_d = S_MEM_RD;
                    OP_SW:   state_d = S_MEM_WR;
                    OP_ADDI: state_d = S_ADDI_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM_RD:    if (mem_ready_i) state_d = S_WB_MEM;
                         else if (timeout) state_d = S_FETCH;
            S_WB_MEM:    state_d = S_FETCH;
            S_MEM_WR:    if (mem_ready_i || timeout) state_d = S_FETCH;
            S_ADDI_WB:   state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    // State register; reset overrides any in-flight access or multiply
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode from state, qualified by handshake/opcode where a pulse depends on them
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        ir_write_o      = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        alu_op_o        = ALUOP_ADD;
        pc_source_o     = PCSRC_ALU;
        mul_start_o     = 1'b0;
        illegal_o       = 1'b0;
        bus_error_o     = timeout;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_ONE;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = SRCB_IMM;
                illegal_o   = !is_legal_op(opcode_i);
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_FUNCT;
            end
            S_MUL_START: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_MUL;
                mul_start_o = 1'b1;
            end
            S_MUL_WAIT: alu_op_o = ALUOP_MUL;
            S_WB_R: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
            end
            S_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_WB_MEM: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            S_ADDI_WB: reg_write_o = 1'b1;
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_SUB;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed checks of the multi-cycle controller output sequences.
// One comparison of the full output vector per clock cycle.
// Inputs driven 1 time unit after each rising edge, outputs sampled 1 unit later.
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       mul_done;

    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, mul_start, illegal, bus_error;
    logic [1:0] alu_src_b, alu_op, pc_source;

    logic [18:0] outs;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Output vector bit positions
    localparam logic [18:0] B_PCW   = 19'(1) << 18;
    localparam logic [18:0] B_PCWC  = 19'(1) << 17;
    localparam logic [18:0] B_IRW   = 19'(1) << 16;
    localparam logic [18:0] B_IORD  = 19'(1) << 15;
    localparam logic [18:0] B_MR    = 19'(1) << 14;
    localparam logic [18:0] B_MW    = 19'(1) << 13;
    localparam logic [18:0] B_M2R   = 19'(1) << 12;
    localparam logic [18:0] B_RD    = 19'(1) << 11;
    localparam logic [18:0] B_RW    = 19'(1) << 10;
    localparam logic [18:0] B_ASA   = 19'(1) << 9;
    localparam logic [18:0] ASB_ONE = 19'(1) << 7;
    localparam logic [18:0] ASB_IMM = 19'(2) << 7;
    localparam logic [18:0] AOP_SUB = 19'(1) << 5;
    localparam logic [18:0] AOP_FN  = 19'(2) << 5;
    localparam logic [18:0] AOP_MUL = 19'(3) << 5;
    localparam logic [18:0] PCS_OUT = 19'(1) << 3;
    localparam logic [18:0] B_MS    = 19'(1) << 2;
    localparam logic [18:0] B_ILL   = 19'(1) << 1;
    localparam logic [18:0] B_BE    = 19'(1);

    // Expected per-state output vectors
    localparam logic [18:0] E_IDLE      = 19'd0;
    localparam logic [18:0] E_FETCH_W   = B_MR | ASB_ONE;
    localparam logic [18:0] E_FETCH_R   = B_MR | ASB_ONE | B_PCW | B_IRW;
    localparam logic [18:0] E_DECODE    = ASB_IMM;
    localparam logic [18:0] E_DEC_ILL   = ASB_IMM | B_ILL;
    localparam logic [18:0] E_EXEC_R    = B_ASA | AOP_FN;
    localparam logic [18:0] E_MUL_START = B_ASA | AOP_MUL | B_MS;
    localparam logic [18:0] E_MUL_WAIT  = AOP_MUL;
    localparam logic [18:0] E_WB_R      = B_RD | B_RW;
    localparam logic [18:0] E_ADDR      = B_ASA | ASB_IMM;
    localparam logic [18:0] E_MEM_RD    = B_MR | B_IORD;
    localparam logic [18:0] E_WB_MEM    = B_M2R | B_RW;
    localparam logic [18:0] E_MEM_WR    = B_MW | B_IORD;
    localparam logic [18:0] E_ADDI_WB   = B_RW;
    localparam logic [18:0] E_BRANCH    = B_ASA | AOP_SUB | B_PCWC | PCS_OUT;

    multicycle_controller #(
        .MEM_TIMEOUT (15),
        .TW          (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .opcode_i        (opcode),
        .mem_ready_i     (mem_ready),
        .mul_done_i      (mul_done),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .ir_write_o      (ir_write),
        .iord_o          (iord),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_to_reg_o    (mem_to_reg),
        .reg_dst_o       (reg_dst),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .pc_source_o     (pc_source),
        .mul_start_o     (mul_start),
        .illegal_o       (illegal),
        .bus_error_o     (bus_error)
    );

    assign outs = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, mul_start, illegal, bus_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check the current cycle's outputs, then advance to 1 unit after the next edge
    task automatic cyc(input logic [18:0] exp, input string tag);
        #1;
        n_checks++;
        assert (outs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", tag, outs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 4'b0000;
        mem_ready = 1'b0;
        mul_done  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc(E_IDLE, "reset_outputs");
        rst = 1'b0;
        cyc(E_IDLE, "idle_after_reset");

        // ADD: 4 cycles with MemReady high
        opcode    = 4'b0110;
        mem_ready = 1'b1;
        cyc(E_FETCH_R, "add_c1_fetch");
        cyc(E_DECODE,  "add_c2_decode");
        cyc(E_EXEC_R,  "add_c3_exec");
        cyc(E_WB_R,    "add_c4_wb");

        // BEQ: 3 cycles
        opcode = 4'b0100;
        cyc(E_FETCH_R, "beq_c1_fetch");
        cyc(E_DECODE,  "beq_c2_decode");
        cyc(E_BRANCH,  "beq_c3_branch");

        // Illegal opcode pulses Illegal, then straight back to FETCH
        opcode = 4'b1111;
        cyc(E_FETCH_R, "ill_fetch");
        cyc(E_DEC_ILL, "ill_decode");

        // ADDI: 4 cycles
        opcode = 4'b0001;
        cyc(E_FETCH_R, "ill_next_fetch");
        cyc(E_DECODE,  "addi_decode");
        cyc(E_ADDR,    "addi_addr");
        cyc(E_ADDI_WB, "addi_wb");

        // SW: 4 cycles
        opcode = 4'b0011;
        cyc(E_FETCH_R, "sw_fetch");
        cyc(E_DECODE,  "sw_decode");
        cyc(E_ADDR,    "sw_addr");
        cyc(E_MEM_WR,  "sw_memwr");

        // LW with MemReady delayed 3 cycles in MEM_RD: 8 cycles
        opcode = 4'b0010;
        cyc(E_FETCH_R, "lw_fetch");
        cyc(E_DECODE,  "lw_decode");
        cyc(E_ADDR,    "lw_addr");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(E_MEM_RD, "lw_memrd_wait");
        mem_ready = 1'b1;
        cyc(E_MEM_RD,  "lw_memrd_ready");
        cyc(E_WB_MEM,  "lw_wbmem");

        // MUL: stray MulDone in FETCH ignored, MulDone 6 cycles after MulStart
        opcode    = 4'b0111;
        mem_ready = 1'b0;
        mul_done  = 1'b1;
        cyc(E_FETCH_W, "mul_fetch_stray_done");
        mul_done  = 1'b0;
        mem_ready = 1'b1;
        cyc(E_FETCH_R,    "mul_fetch");
        cyc(E_DECODE,     "mul_decode");
        cyc(E_MUL_START,  "mul_start");
        for (int i = 0; i < 5; i++) cyc(E_MUL_WAIT, "mul_wait");
        mul_done = 1'b1;
        cyc(E_MUL_WAIT,   "mul_wait_done");
        mul_done = 1'b0;
        cyc(E_WB_R,       "mul_wb");

        // Fetch timeout: 15 wait cycles, then BusError with no PcWrite
        mem_ready = 1'b0;
        opcode    = 4'b0010;
        for (int i = 0; i < 15; i++) cyc(E_FETCH_W, "fto_wait");
        cyc(E_FETCH_W | B_BE, "fto_buserr");
        // Retry: MemReady on the timeout cycle wins
        for (int i = 0; i < 15; i++) cyc(E_FETCH_W, "fto_retry_wait");
        mem_ready = 1'b1;
        cyc(E_FETCH_R, "fto_ready_wins");

        // Reset in the middle of MEM_RD
        cyc(E_DECODE, "rst_lw_decode");
        cyc(E_ADDR,   "rst_lw_addr");
        mem_ready = 1'b0;
        cyc(E_MEM_RD, "rst_lw_memrd");
        rst = 1'b1;
        cyc(E_MEM_RD, "rst_lw_memrd_held");
        rst = 1'b0;
        cyc(E_IDLE,    "rst_mid_memrd_idle");
        cyc(E_FETCH_W, "rst_then_fetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
